// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and
// the elaboration-time parameter legality check.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A width/stage pair is usable only when the width splits into equal,
  // non-empty chunks.
  function automatic bit paramsLegal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple adder for one chunk of the pipelined adder. Besides the
// chunk sum and carry-out it exposes the carry into the chunk MSB, which the
// top chunk uses to form the signed-overflow flag.
module adder_chunk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    fulladder uFa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (carry[i]),
      .sum_o (sum_o[i]),
      .cout_o(carry[i+1])
    );
  end

  assign cout_o = carry[WIDTH];
  assign cmsb_o = carry[WIDTH-1];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell, the leaf of every ripple chain in the adder.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Classic sum/majority-carry equations.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// The operand is split into STAGES chunks; stage k resolves chunk k using the
// carry registered by stage k-1, while the untouched operand bits and the
// already-resolved sum bits travel alongside. The whole pipe stalls together
// whenever the output holds a result that downstream has not taken.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  // Operand registers are needed only between stages, never after the last.
  localparam int PIPE  = (STAGES > 1) ? STAGES - 1 : 1;

  if (!paramsLegal(WIDTH, STAGES)) begin : gBadParams
    $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic                          advance;
  logic [WIDTH-1:0]              bEff;
  logic                          cinEff;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0]  partSum_q, partSum_d;
  logic [PIPE-1:0][WIDTH-1:0]    opA_q, opA_d;
  logic [PIPE-1:0][WIDTH-1:0]    opB_q, opB_d;
  logic                          ovf_q, ovf_d;

  logic [STAGES-1:0][WIDTH-1:0]  srcA, srcB, srcSum;
  logic [STAGES-1:0]             srcCin, srcValid;
  logic [STAGES-1:0][CHUNK-1:0]  chunkA, chunkB, chunkSum;
  logic [STAGES-1:0]             chunkCout, chunkCmsb;

  // Subtraction is a + ~b + 1, so invert b and force the first carry-in.
  always_comb begin
    bEff   = (sub == MODE_SUB) ? ~b : b;
    cinEff = (sub == MODE_SUB) ? 1'b1 : cin;
  end

  // Global stall: everything moves unless a finished result is being held.
  // Reset forces ready so upstream never sees back-pressure during reset.
  always_comb begin
    advance  = !valid_q[STAGES-1] | out_ready;
    in_ready = advance | rst;
  end

  // Gather each stage's inputs (from the ports for stage 0, otherwise from
  // the previous stage registers) and cut out the chunk this stage resolves.
  always_comb begin
    srcA     = '0;
    srcB     = '0;
    srcSum   = '0;
    srcCin   = '0;
    srcValid = '0;
    chunkA   = '0;
    chunkB   = '0;
    chunkCin_loop: for (int k = 0; k < STAGES; k++) begin
      int p;
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        srcA[k]     = a;
        srcB[k]     = bEff;
        srcSum[k]   = '0;
        srcCin[k]   = cinEff;
        srcValid[k] = in_valid;
      end else begin
        srcA[k]     = opA_q[p];
        srcB[k]     = opB_q[p];
        srcSum[k]   = partSum_q[p];
        srcCin[k]   = carry_q[p];
        srcValid[k] = valid_q[p];
      end
      chunkA[k] = CHUNK'(srcA[k] >> (k * CHUNK));
      chunkB[k] = CHUNK'(srcB[k] >> (k * CHUNK));
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    adder_chunk #(.WIDTH(CHUNK)) uChunk (
      .a_i   (chunkA[k]),
      .b_i   (chunkB[k]),
      .cin_i (srcCin[k]),
      .sum_o (chunkSum[k]),
      .cout_o(chunkCout[k]),
      .cmsb_o(chunkCmsb[k])
    );
  end

  // Build each stage's next register contents: merge the freshly resolved
  // chunk into the running sum and forward the operands for later stages.
  always_comb begin
    valid_d   = '0;
    carry_d   = '0;
    partSum_d = '0;
    opA_d     = '0;
    opB_d     = '0;
    for (int k = 0; k < STAGES; k++) begin
      int q;
      q = (k < PIPE) ? k : PIPE - 1;
      valid_d[k]                      = srcValid[k];
      carry_d[k]                      = chunkCout[k];
      partSum_d[k]                    = srcSum[k];
      partSum_d[k][k*CHUNK +: CHUNK]  = chunkSum[k];
      if (k < STAGES - 1) begin
        opA_d[q] = srcA[k];
        opB_d[q] = srcB[k];
      end
    end
    ovf_d = chunkCmsb[STAGES-1] ^ chunkCout[STAGES-1];
  end

  // Stage registers: cleared by reset, loaded together on advance, frozen
  // during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      carry_q   <= '0;
      partSum_q <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (advance) begin
      valid_q   <= valid_d;
      carry_q   <= carry_d;
      partSum_q <= partSum_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = partSum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: a 16-bit/4-stage instance for latency,
// subtract, overflow, back-pressure and mid-flight reset, plus an
// 8-bit/1-stage instance for the degenerate registered-adder case.
module tb_adder_pipe;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          inValid, inReady, cin, sub, outValid, outReady, cout, ovf;
  logic [W-1:0]  a, b, sum;

  logic          inValid8, inReady8, cin8, sub8, outValid8, outReady8, cout8, ovf8;
  logic [W8-1:0] a8, b8, sum8;

  int errorCount = 0;
  int checkCount = 0;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid), .out_ready(outReady),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(W8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(outValid8), .out_ready(outReady8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle on the 16-bit instance.
  task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input logic cinIn, input logic subIn);
    a = aIn; b = bIn; cin = cinIn; sub = subIn; inValid = 1'b1;
    #1;
    checkOutput("accept_ready", inReady, 1);
    tick;
    inValid = 1'b0;
  endtask

  // Wait (bounded) for the result and check its latency and value.
  task automatic waitResult(input string tag, input logic [W-1:0] expSum,
                            input logic expCout, input logic expOvf);
    int n;
    n = 1;
    while (!outValid && n < 12) begin
      tick;
      n++;
    end
    checkOutput({tag, "_latency"}, n, S);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, cout, expCout);
    checkOutput({tag, "_ovf"}, ovf, expOvf);
  endtask

  // Reference: {ovf, cout, sum} from plain integer addition.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         o;
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + (W+1)'(rs ? 1'b1 : rc);
    o    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return {o, full};
  endfunction

  logic [W-1:0]   va [20];
  logic [W-1:0]   vb [20];
  logic           vc [20];
  logic           vs [20];
  logic [W+1:0]   expQ [$];

  logic [W8-1:0]  t8a [4] = '{8'hFF, 8'h7F, 8'h10, 8'h80};
  logic [W8-1:0]  t8b [4] = '{8'hFF, 8'h01, 8'h20, 8'h01};
  logic           t8c [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic           t8s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W8-1:0]  t8sum [4] = '{8'hFF, 8'h80, 8'hF0, 8'h7F};
  logic           t8co [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic           t8ov [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int sent, recv;
    logic stalled;
    logic [W-1:0] holdSum;
    logic [W+1:0] exp;

    rst = 1'b1;
    inValid = 0; a = '0; b = '0; cin = 0; sub = 0; outReady = 1'b1;
    inValid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; outReady8 = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_valid8", outValid8, 0);

    // Directed add/subtract/overflow vectors
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitResult("ripple", 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    waitResult("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    waitResult("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    waitResult("add_ovf", 16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
    waitResult("add_cin", 16'h5556, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    waitResult("neg_wrap", 16'h0000, 1'b1, 1'b1);
    tick;
    checkOutput("drain_valid", outValid, 0);

    // Back-pressure stream against the reference model
    for (int i = 0; i < 20; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; stalled = 1'b0; holdSum = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      inValid = (sent < 20);
      if (sent < 20) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      outReady = 1'($urandom_range(0, 1));
      #1;
      checkOutput("bp_in_ready", inReady, 32'(!outValid | outReady));
      if (stalled) begin
        checkOutput("bp_hold_valid", outValid, 1);
        checkOutput("bp_hold_sum", sum, holdSum);
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("bp_extra_beat", outValid, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("bp_sum", sum, exp[W-1:0]);
          checkOutput("bp_cout", cout, exp[W]);
          checkOutput("bp_ovf", ovf, exp[W+1]);
          recv++;
        end
      end
      stalled = outValid && !outReady;
      holdSum = sum;
      if (inValid && inReady) begin
        expQ.push_back(refModel(a, b, cin, sub));
        sent++;
      end
      tick;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checkOutput("bp_received", recv, 20);
    tick;
    checkOutput("bp_drained", outValid, 0);

    // Reset with beats in flight and the output stalled
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0100 * (i + 1)); b = 16'h0011; cin = 0; sub = 0; inValid = 1'b1;
      tick;
    end
    inValid = 1'b0;
    tick;
    checkOutput("rst_full_valid", outValid, 1);
    checkOutput("rst_stall_ready", inReady, 0);
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", inReady, 1);
    tick;
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_sum", sum, 0);
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checkOutput("rst_no_stale", outValid, 0);
    end
    applyStimulus(16'h00F0, 16'h000F, 1'b1, 1'b0);
    waitResult("post_rst", 16'h0100, 1'b0, 1'b0);
    tick;

    // Single-stage, 8-bit instance: latency 1, one beat per cycle
    for (int i = 0; i < 4; i++) begin
      a8 = t8a[i]; b8 = t8b[i]; cin8 = t8c[i]; sub8 = t8s[i]; inValid8 = 1'b1;
      #1;
      checkOutput("s1_in_ready", inReady8, 1);
      tick;
      checkOutput("s1_valid", outValid8, 1);
      checkOutput("s1_sum", sum8, t8sum[i]);
      checkOutput("s1_cout", cout8, t8co[i]);
      checkOutput("s1_ovf", ovf8, t8ov[i]);
    end
    inValid8 = 1'b0;
    tick;
    checkOutput("s1_idle", outValid8, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
